// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and field bounds for the 24-bit run sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD_W = 24;
    localparam int OPC_HI = 23;
    localparam int OPC_LO = 20;
    localparam int IMM_HI = 11;
    localparam int IMM_LO = 0;

    localparam logic [3:0]        HALT_OPCODE_DEF = 4'hF;
    localparam logic [WORD_W-1:0] PC_STEP_DEF     = 24'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXEC      = 3'd2,
        ST_WAIT_STEP = 3'd3,
        ST_HALT      = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_sequencer_if
// Brief    : Control, fetch and datapath bundle between sequencer and system.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_sequencer_if;
    import cpu_pkg::*;

    logic              Start;
    logic              StepMode;
    logic              Step;
    logic              ImemReq;
    logic [WORD_W-1:0] ImemAddr;
    logic              ImemAck;
    logic [WORD_W-1:0] ImemData;
    logic [WORD_W-1:0] Instruction;
    logic [WORD_W-1:0] PC;
    logic              ExecEn;
    logic              BranchTaken;
    logic              Halted;
    logic              Error;
    logic [15:0]       InstrCount;

    modport master (
        input  Start, StepMode, Step, ImemAck, ImemData, BranchTaken,
        output ImemReq, ImemAddr, Instruction, PC, ExecEn, Halted, Error,
               InstrCount
    );

    modport slave (
        output Start, StepMode, Step, ImemAck, ImemData, BranchTaken,
        input  ImemReq, ImemAddr, Instruction, PC, ExecEn, Halted, Error,
               InstrCount
    );

endinterface
`default_nettype wire

// File: rtl/cpu_run_sequencer_pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_calc
// Brief    : Next-PC adder: PC + step, plus sign-extended imm12 when branching.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_STEP = PC_STEP_DEF
) (
    input  wire logic [WORD_W-1:0] i_pc,
    input  wire logic [11:0]       i_imm12,
    input  wire logic              i_branch_taken,
    output logic      [WORD_W-1:0] o_pc_next
);

    logic [WORD_W-1:0] w_offset;

    // Sums are deliberately WORD_W wide so the address space wraps.
    assign w_offset  = i_branch_taken ? {{(WORD_W-12){i_imm12[11]}}, i_imm12} : '0;
    assign o_pc_next = i_pc + PC_STEP + w_offset;

endmodule
`default_nettype wire

// File: rtl/cpu_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_sequencer
// Brief    : Multi-cycle fetch/execute sequencer owning the PC register.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_sequencer
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = 24'd0,
    parameter logic [WORD_W-1:0] PC_STEP     = PC_STEP_DEF,
    parameter logic [3:0]        HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int                TIMEOUT     = 8
) (
    input  wire logic               Clock,
    input  wire logic               Reset,
    cpu_run_sequencer_if.master     bus
);

    localparam int                  c_tmo_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   r_instr;
    logic [WORD_W-1:0]   w_pc_next;
    logic [15:0]         r_count;
    logic [c_tmo_w-1:0]  r_tmo;
    logic                w_is_halt;

    assign w_is_halt = (bus.ImemData[OPC_HI:OPC_LO] == HALT_OPCODE);

    pc_next_calc #(
        .PC_STEP        (PC_STEP)
    ) u_pc_next (
        .i_pc           (r_pc),
        .i_imm12        (r_instr[IMM_HI:IMM_LO]),
        .i_branch_taken (bus.BranchTaken),
        .o_pc_next      (w_pc_next)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_count <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_FETCH: begin
                    if (bus.ImemAck) begin
                        r_instr <= bus.ImemData;
                    end
                    // Counter clears on ack so every fetch gets a fresh budget.
                    if (bus.ImemAck || (r_tmo == c_tmo_last)) begin
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_pc    <= w_pc_next;
                    r_count <= r_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (bus.Start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // A halt word is latched but never executed; PC stays put.
                if (bus.ImemAck) begin
                    w_state_nxt = w_is_halt ? ST_HALT : ST_EXEC;
                end else if (r_tmo == c_tmo_last) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_EXEC: begin
                w_state_nxt = bus.StepMode ? ST_WAIT_STEP : ST_FETCH;
            end
            ST_WAIT_STEP: begin
                if (!bus.StepMode || bus.Step) w_state_nxt = ST_FETCH;
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.ImemReq     = (r_state == ST_FETCH);
    assign bus.ImemAddr    = r_pc;
    assign bus.PC          = r_pc;
    assign bus.Instruction = r_instr;
    assign bus.ExecEn      = (r_state == ST_EXEC);
    assign bus.Halted      = (r_state == ST_HALT);
    assign bus.Error       = (r_state == ST_ERROR);
    assign bus.InstrCount  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_sequencer
// Brief    : Directed self-checking bench for cpu_run_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_sequencer;

    logic clk;
    logic rst;
    int   test_cnt;
    int   fail_cnt;

    cpu_run_sequencer_if bus ();

    cpu_run_sequencer dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge while the sequencer sits in FETCH; leaves just after EXEC.
    task automatic do_instr(input logic [23:0] addr, input logic [23:0] data,
                            input logic br, input int waits);
        chk("fetch_req",  32'(bus.ImemReq),  32'd1);
        chk("fetch_addr", 32'(bus.ImemAddr), 32'(addr));
        chk("fetch_noexec", 32'(bus.ExecEn), 32'd0);
        for (int i = 0; i < waits; i++) begin
            bus.ImemAck = 1'b0;
            tick();
        end
        bus.ImemAck     = 1'b1;
        bus.ImemData    = data;
        bus.BranchTaken = br;
        tick();
        bus.ImemAck = 1'b0;
        chk("exec_en",    32'(bus.ExecEn),      32'd1);
        chk("exec_instr", 32'(bus.Instruction), 32'(data));
        chk("exec_noreq", 32'(bus.ImemReq),     32'd0);
        chk("exec_err",   32'(bus.Error),       32'd0);
        tick();
        bus.BranchTaken = 1'b0;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    initial begin
        test_cnt        = 0;
        fail_cnt        = 0;
        rst             = 1'b1;
        bus.Start       = 1'b0;
        bus.StepMode    = 1'b0;
        bus.Step        = 1'b0;
        bus.ImemAck     = 1'b0;
        bus.ImemData    = '0;
        bus.BranchTaken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc",    32'(bus.PC),          32'd0);
        chk("rst_instr", 32'(bus.Instruction), 32'd0);
        chk("rst_req",   32'(bus.ImemReq),     32'd0);
        chk("rst_exec",  32'(bus.ExecEn),      32'd0);
        chk("rst_halt",  32'(bus.Halted),      32'd0);
        chk("rst_err",   32'(bus.Error),       32'd0);
        chk("rst_cnt",   32'(bus.InstrCount),  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_quiet", 32'(bus.ImemReq), 32'd0);

        // Zero-wait straight-line run
        pulse_start();
        do_instr(24'h000000, 24'h100000, 1'b0, 0);
        do_instr(24'h000003, 24'h200000, 1'b0, 0);
        do_instr(24'h000006, 24'h300000, 1'b0, 0);
        chk("cnt_after3", 32'(bus.InstrCount), 32'd3);

        // Branches: 9+3-6 = 6, then 9+3+16 = 0x1C, then 0x1C+3-19 = 0x0C
        do_instr(24'h000009, 24'h000FFA, 1'b1, 0);
        do_instr(24'h000006, 24'h000FFF, 1'b0, 0);
        do_instr(24'h000009, 24'h000010, 1'b1, 0);
        do_instr(24'h00001C, 24'h000FED, 1'b1, 0);
        chk("cnt_before_halt", 32'(bus.InstrCount), 32'd7);

        // Halt word at 0x0C
        chk("halt_addr", 32'(bus.ImemAddr), 32'h00000C);
        bus.ImemAck  = 1'b1;
        bus.ImemData = 24'hF00000;
        tick();
        bus.ImemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("halted",      32'(bus.Halted),     32'd1);
            chk("halt_noexec", 32'(bus.ExecEn),     32'd0);
            chk("halt_pc",     32'(bus.PC),         32'h00000C);
            chk("halt_cnt",    32'(bus.InstrCount), 32'd7);
            tick();
        end
        pulse_start();
        chk("restart_halt", 32'(bus.Halted), 32'd0);
        // 0x0C+3-17 = 0xFFFFFE, then wrap to 0x000001
        do_instr(24'h00000C, 24'h000FEF, 1'b1, 0);
        do_instr(24'hFFFFFE, 24'h000FFF, 1'b0, 0);
        chk("cnt_after_wrap", 32'(bus.InstrCount), 32'd9);
        chk("wrap_addr",      32'(bus.ImemAddr),   32'h000001);

        // Withheld ack: error after 8 FETCH cycles
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_pre_err", 32'(bus.Error),   32'd0);
        chk("tmo_pre_req", 32'(bus.ImemReq), 32'd1);
        tick();
        chk("tmo_err", 32'(bus.Error),   32'd1);
        chk("tmo_req", 32'(bus.ImemReq), 32'd0);
        pulse_start();
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        chk("err_sticky", 32'(bus.Error),  32'd1);
        chk("err_noexec", 32'(bus.ExecEn), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_rst_err", 32'(bus.Error), 32'd0);
        chk("err_rst_pc",  32'(bus.PC),    32'd0);

        // Ack on the 8th FETCH cycle wins over timeout
        pulse_start();
        do_instr(24'h000000, 24'h123456, 1'b0, 7);

        // Single-step; a Step during FETCH must not be remembered
        bus.StepMode = 1'b1;
        bus.Step     = 1'b1;
        tick();
        bus.Step = 1'b0;
        do_instr(24'h000003, 24'h111111, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("wait_noreq",  32'(bus.ImemReq), 32'd0);
            chk("wait_noexec", 32'(bus.ExecEn),  32'd0);
            tick();
        end
        pulse_start();
        chk("wait_start_ign", 32'(bus.ImemReq), 32'd0);
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        do_instr(24'h000006, 24'h222222, 1'b0, 0);
        chk("step_cnt", 32'(bus.InstrCount), 32'd3);
        bus.StepMode = 1'b0;
        tick();

        // Reset coinciding with an ack mid-fetch
        chk("pre_rst_addr", 32'(bus.ImemAddr), 32'h000009);
        bus.ImemAck  = 1'b1;
        bus.ImemData = 24'h654321;
        rst          = 1'b1;
        tick();
        bus.ImemAck = 1'b0;
        rst         = 1'b0;
        chk("mid_rst_instr", 32'(bus.Instruction), 32'd0);
        chk("mid_rst_pc",    32'(bus.PC),          32'd0);
        chk("mid_rst_req",   32'(bus.ImemReq),     32'd0);
        chk("mid_rst_exec",  32'(bus.ExecEn),      32'd0);
        chk("mid_rst_cnt",   32'(bus.InstrCount),  32'd0);
        tick();
        chk("mid_rst_idle",  32'(bus.ExecEn),      32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
